// File: rtl/icache_pkg.sv
// Shared constants for the instruction-cache fill controller: FSM encoding and default widths.
package icache_pkg;

    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_ADDR_WIDTH = 19;

    typedef logic [1:0] fill_state_t;

    localparam fill_state_t ST_IDLE = 2'd0;
    localparam fill_state_t ST_FILL = 2'd1;
    localparam fill_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Streams source words into the instruction RAM write port while stalling the fetch stage.
// Optional running checksum of the loaded words: define ICACHE_FILL_CHECKSUM_EN.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_cnt,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  busy,
    output logic                  done,
`ifdef ICACHE_FILL_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] exp_sum,
    output logic                  sum_err,
`endif
    output logic                  core_stall
);

    fill_state_t           state_q, state_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  wea_q, wea_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dina_q, dina_d;
    logic                  start_ok;
    logic                  accept;

    assign s_ready  = (state_q == ST_FILL) && !abort;
    assign accept   = s_valid && s_ready;
    assign start_ok = (state_q == ST_IDLE) && start;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
        state_d  = state_q;
        remain_d = remain_q;
        waddr_d  = waddr_q;
        wea_d    = accept;
        addra_d  = addra_q;
        dina_d   = dina_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    waddr_d  = base_addr;
                    remain_d = word_cnt;
                    state_d  = (word_cnt == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    addra_d  = waddr_q;
                    dina_d   = s_data;
                    waddr_d  = waddr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - (ADDR_WIDTH+1)'(1);
                    if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            waddr_q  <= '0;
            wea_q    <= 1'b0;
            addra_q  <= '0;
            dina_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            waddr_q  <= waddr_d;
            wea_q    <= wea_d;
            addra_q  <= addra_d;
            dina_q   <= dina_d;
        end
    end

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign core_stall = busy || wea_q;

`ifdef ICACHE_FILL_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, exp_q;
    logic                  sum_err_q;

    // The verdict is latched in DONE and survives aborts until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            exp_q     <= '0;
            sum_err_q <= 1'b0;
        end else if (start_ok) begin
            sum_q     <= '0;
            exp_q     <= exp_sum;
            sum_err_q <= 1'b0;
        end else begin
            if (accept) sum_q <= sum_q + s_data;
            if (state_q == ST_DONE) sum_err_q <= (sum_q != exp_q);
        end
    end

    assign sum_err = sum_err_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule
